// File: rtl/vga_timing_pkg.sv
// ---------------------------------------------------------------------------
// vga_timing_pkg
// Shared constants and types for the 640x480@60Hz raster generator.
//   - horizontal / vertical timing (visible, porches, sync) and derived totals
//   - sync start/end positions expressed as coordinate values
//   - coord_t : 10-bit raster coordinate
//   - rgb_t   : packed 8:8:8 colour
//   - test_bar(): colour of the 8-bar test pattern for a given x
// Optional feature macro used by the top level: VGA_TIMING_PATTERN_EN
// ---------------------------------------------------------------------------
package vga_timing_pkg;

    localparam int H_VISIBLE = 640;
    localparam int H_FRONT   = 16;
    localparam int H_SYNC    = 96;
    localparam int H_BACK    = 48;
    localparam int H_TOTAL   = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;

    localparam int V_VISIBLE = 480;
    localparam int V_FRONT   = 10;
    localparam int V_SYNC    = 2;
    localparam int V_BACK    = 33;
    localparam int V_TOTAL   = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    localparam int COORD_W = 10;

    typedef logic [COORD_W-1:0] coord_t;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb_t;

    localparam coord_t H_VIS_LIMIT    = coord_t'(H_VISIBLE);
    localparam coord_t H_SYNC_START_C = coord_t'(H_VISIBLE + H_FRONT);
    localparam coord_t H_SYNC_END_C   = coord_t'(H_VISIBLE + H_FRONT + H_SYNC - 1);
    localparam coord_t V_VIS_LIMIT    = coord_t'(V_VISIBLE);
    localparam coord_t V_SYNC_START_C = coord_t'(V_VISIBLE + V_FRONT);
    localparam coord_t V_SYNC_END_C   = coord_t'(V_VISIBLE + V_FRONT + V_SYNC - 1);

    localparam coord_t BAR_WIDTH = coord_t'(80);

    // Bars are white, yellow, cyan, green, magenta, red, blue, black.
    // With bar index b, each channel is simply an inverted bit of b.
    function automatic rgb_t test_bar(input coord_t x);
        logic [2:0] bar;
        rgb_t       c;
        bar = 3'(x / BAR_WIDTH);
        c.r = {8{~bar[1]}};
        c.g = {8{~bar[2]}};
        c.b = {8{~bar[0]}};
        return c;
    endfunction

endpackage

// File: rtl/vga_mod_counter.sv
// ---------------------------------------------------------------------------
// vga_mod_counter
// Modulo-N up counter with count enable and a wrap pulse.
//   CLOCK_50_I : clock
//   resetn     : asynchronous active-low reset (count -> 0)
//   en         : advance the count this cycle
//   count      : current value, 0..MODULUS-1
//   wrap       : high in the cycle the counter is enabled at MODULUS-1
// ---------------------------------------------------------------------------
module vga_mod_counter #(
    parameter int MODULUS = 800,
    parameter int WIDTH   = 10
) (
    input  logic             CLOCK_50_I,
    input  logic             resetn,
    input  logic             en,
    output logic [WIDTH-1:0] count,
    output logic             wrap
);

    localparam logic [WIDTH-1:0] LAST = WIDTH'(MODULUS - 1);

    logic [WIDTH-1:0] count_q;

    assign wrap  = en && (count_q == LAST);
    assign count = count_q;

    always_ff @(posedge CLOCK_50_I or negedge resetn) begin
        if (!resetn) begin
            count_q <= '0;
        end else if (en) begin
            count_q <= wrap ? '0 : count_q + 1'b1;
        end
    end

endmodule

// File: rtl/vga_timing_gen.sv
// ---------------------------------------------------------------------------
// vga_timing_gen
// 640x480@60Hz raster timing generator with registered colour/sync outputs.
// State only advances on the pixel strobe 'enable'.
//   CLOCK_50_I, resetn        : 50 MHz clock, async active-low reset
//   enable                    : pixel strobe
//   iPattern_sel              : select internal colour bars
//   iRed/iGreen/iBlue         : colour for the current oCoord
//   oCoord_X/oCoord_Y         : raster counters (0..799 / 0..524)
//   oFrame_start              : strobe at the last pixel of a frame
//   oVGA_R/G/B                : registered colour (0 when blanked)
//   oVGA_H_SYNC/oVGA_V_SYNC   : active-low syncs
//   oVGA_BLANK                : 1 = visible pixel
//   oVGA_SYNC                 : constant 0
// Build option: define VGA_TIMING_PATTERN_EN to enable the 8-bar test
// pattern on iPattern_sel; otherwise iPattern_sel is ignored.
// Registered outputs trail oCoord by exactly one strobe.
// ---------------------------------------------------------------------------
module vga_timing_gen
    import vga_timing_pkg::*;
(
    input  logic       CLOCK_50_I,
    input  logic       resetn,
    input  logic       enable,
    input  logic       iPattern_sel,
    input  logic [7:0] iRed,
    input  logic [7:0] iGreen,
    input  logic [7:0] iBlue,
    output coord_t     oCoord_X,
    output coord_t     oCoord_Y,
    output logic       oFrame_start,
    output logic [7:0] oVGA_R,
    output logic [7:0] oVGA_G,
    output logic [7:0] oVGA_B,
    output logic       oVGA_H_SYNC,
    output logic       oVGA_V_SYNC,
    output logic       oVGA_BLANK,
    output logic       oVGA_SYNC
);

    coord_t h_cnt;
    coord_t v_cnt;
    logic   h_wrap;
    logic   v_wrap;

    vga_mod_counter #(.MODULUS(H_TOTAL), .WIDTH(COORD_W)) u_h_cnt (
        .CLOCK_50_I (CLOCK_50_I),
        .resetn     (resetn),
        .en         (enable),
        .count      (h_cnt),
        .wrap       (h_wrap)
    );

    // h_wrap already includes enable, so the line counter steps once per line.
    vga_mod_counter #(.MODULUS(V_TOTAL), .WIDTH(COORD_W)) u_v_cnt (
        .CLOCK_50_I (CLOCK_50_I),
        .resetn     (resetn),
        .en         (h_wrap),
        .count      (v_cnt),
        .wrap       (v_wrap)
    );

    logic vis;
    logic hs_n;
    logic vs_n;
    rgb_t pix_c;

    assign vis  = (h_cnt < H_VIS_LIMIT) && (v_cnt < V_VIS_LIMIT);
    assign hs_n = !((h_cnt >= H_SYNC_START_C) && (h_cnt <= H_SYNC_END_C));
    assign vs_n = !((v_cnt >= V_SYNC_START_C) && (v_cnt <= V_SYNC_END_C));

`ifdef VGA_TIMING_PATTERN_EN
    always_comb begin
        pix_c = '{r: iRed, g: iGreen, b: iBlue};
        if (iPattern_sel) begin
            pix_c = test_bar(h_cnt);
        end
    end
`else
    logic unused_pattern_sel;
    assign unused_pattern_sel = iPattern_sel;

    always_comb begin
        pix_c = '{r: iRed, g: iGreen, b: iBlue};
    end
`endif

    rgb_t rgb_q;
    logic hs_q;
    logic vs_q;
    logic blank_q;

    always_ff @(posedge CLOCK_50_I or negedge resetn) begin
        if (!resetn) begin
            rgb_q   <= '0;
            hs_q    <= 1'b1;
            vs_q    <= 1'b1;
            blank_q <= 1'b0;
        end else if (enable) begin
            rgb_q   <= vis ? pix_c : '0;
            hs_q    <= hs_n;
            vs_q    <= vs_n;
            blank_q <= vis;
        end
    end

    assign oCoord_X     = h_cnt;
    assign oCoord_Y     = v_cnt;
    assign oFrame_start = v_wrap;
    assign oVGA_R       = rgb_q.r;
    assign oVGA_G       = rgb_q.g;
    assign oVGA_B       = rgb_q.b;
    assign oVGA_H_SYNC  = hs_q;
    assign oVGA_V_SYNC  = vs_q;
    assign oVGA_BLANK   = blank_q;
    assign oVGA_SYNC    = 1'b0;

endmodule

// File: tb/tb_vga_timing_gen.sv
// ---------------------------------------------------------------------------
// tb_vga_timing_gen
// Self-checking bench for vga_timing_gen. The reference keeps a single pixel
// index n (strobes since reset, modulo one frame); coordinates follow as
// n%800 and n/800, and the expected registered outputs are computed from the
// raster rules for the coordinate just left. To reach distant raster
// positions quickly the counters are placed with force/release.
// Honours VGA_TIMING_PATTERN_EN the same way as the design.
// ---------------------------------------------------------------------------
module tb_vga_timing_gen;

    logic       CLOCK_50_I = 1'b0;
    logic       resetn = 1'b0;
    logic       enable = 1'b0;
    logic       iPattern_sel = 1'b0;
    logic [7:0] iRed = 8'h00;
    logic [7:0] iGreen = 8'h00;
    logic [7:0] iBlue = 8'h00;
    logic [9:0] oCoord_X;
    logic [9:0] oCoord_Y;
    logic       oFrame_start;
    logic [7:0] oVGA_R;
    logic [7:0] oVGA_G;
    logic [7:0] oVGA_B;
    logic       oVGA_H_SYNC;
    logic       oVGA_V_SYNC;
    logic       oVGA_BLANK;
    logic       oVGA_SYNC;

    vga_timing_gen dut (
        .CLOCK_50_I   (CLOCK_50_I),
        .resetn       (resetn),
        .enable       (enable),
        .iPattern_sel (iPattern_sel),
        .iRed         (iRed),
        .iGreen       (iGreen),
        .iBlue        (iBlue),
        .oCoord_X     (oCoord_X),
        .oCoord_Y     (oCoord_Y),
        .oFrame_start (oFrame_start),
        .oVGA_R       (oVGA_R),
        .oVGA_G       (oVGA_G),
        .oVGA_B       (oVGA_B),
        .oVGA_H_SYNC  (oVGA_H_SYNC),
        .oVGA_V_SYNC  (oVGA_V_SYNC),
        .oVGA_BLANK   (oVGA_BLANK),
        .oVGA_SYNC    (oVGA_SYNC)
    );

    always #10 CLOCK_50_I = ~CLOCK_50_I;

    localparam int FRAME = 800 * 525;

    logic [23:0] bar_tab [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                                 24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};

    int n_total = 0;
    int n_bad   = 0;

    // reference state
    int          mdl_n     = 0;
    bit          mdl_known = 1'b1;
    logic [23:0] exp_rgb   = 24'h0;
    logic        exp_hs    = 1'b1;
    logic        exp_vs    = 1'b1;
    logic        exp_blank = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            if (n_bad <= 40)
                $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        mdl_n     = 0;
        mdl_known = 1'b1;
        exp_rgb   = 24'h0;
        exp_hs    = 1'b1;
        exp_vs    = 1'b1;
        exp_blank = 1'b0;
    endtask

    task automatic model_step();
        int h;
        int v;
        bit vis;
        logic [23:0] c;
        if (resetn && enable) begin
            h   = mdl_n % 800;
            v   = mdl_n / 800;
            vis = (h < 640) && (v < 480);
            c   = {iRed, iGreen, iBlue};
`ifdef VGA_TIMING_PATTERN_EN
            if (iPattern_sel && h < 640) c = bar_tab[h / 80];
`endif
            exp_rgb   = vis ? c : 24'h0;
            exp_blank = vis;
            exp_hs    = !(h >= 656 && h <= 751);
            exp_vs    = !(v >= 490 && v <= 491);
            mdl_known = 1'b1;
            mdl_n     = (mdl_n + 1) % FRAME;
        end
    endtask

    task automatic compare_all();
        int h;
        int v;
        h = mdl_n % 800;
        v = mdl_n / 800;
        chk("coord_x", 32'(oCoord_X), 32'(h));
        chk("coord_y", 32'(oCoord_Y), 32'(v));
        chk("frame_start", 32'(oFrame_start), 32'(resetn && enable && h == 799 && v == 524));
        chk("sync", 32'(oVGA_SYNC), 32'(0));
        if (mdl_known) begin
            chk("rgb", 32'({oVGA_R, oVGA_G, oVGA_B}), 32'(exp_rgb));
            chk("hsync", 32'(oVGA_H_SYNC), 32'(exp_hs));
            chk("vsync", 32'(oVGA_V_SYNC), 32'(exp_vs));
            chk("blank", 32'(oVGA_BLANK), 32'(exp_blank));
        end
    endtask

    // One clock: compare on the falling edge, advance the reference on the
    // rising edge, return 3 ns later where the caller may change inputs.
    task automatic cyc();
        @(negedge CLOCK_50_I);
        compare_all();
        @(posedge CLOCK_50_I);
        model_step();
        #3;
    endtask

    task automatic rand_colour();
        iRed   = 8'($urandom);
        iGreen = 8'($urandom);
        iBlue  = 8'($urandom);
    endtask

    task automatic jump_to(input int h, input int v);
        enable = 1'b0;
        force dut.u_h_cnt.count_q = 10'(h);
        force dut.u_v_cnt.count_q = 10'(v);
        #1;
        release dut.u_h_cnt.count_q;
        release dut.u_v_cnt.count_q;
        mdl_n     = v * 800 + h;
        mdl_known = 1'b0;
    endtask

    initial begin
        int          hs_low;
        int          vs_low;
        int          fall_x;
        int          vis_ff;
        int          blk_zero;
        int          fs_cnt;
        logic        prev_hs;
        logic [23:0] pat_exp [3];

        model_reset();
        repeat (3) @(posedge CLOCK_50_I);
        #3;
        cyc();
        chk("rst_x", 32'(oCoord_X), 32'd0);
        chk("rst_hsync", 32'(oVGA_H_SYNC), 32'd1);
        chk("rst_blank", 32'(oVGA_BLANK), 32'd0);
        resetn = 1'b1;

        // line 0: pattern select with fixed input colour
`ifdef VGA_TIMING_PATTERN_EN
        pat_exp = '{24'hFFFFFF, 24'hFFFF00, 24'h000000};
`else
        pat_exp = '{24'h5A1122, 24'h5A1122, 24'h5A1122};
`endif
        iPattern_sel = 1'b1;
        iRed = 8'h5A; iGreen = 8'h11; iBlue = 8'h22;
        enable = 1'b1;
        hs_low  = 0;
        fall_x  = -1;
        prev_hs = 1'b1;
        for (int i = 0; i < 800; i++) begin
            cyc();
            if (!oVGA_H_SYNC) hs_low++;
            if (prev_hs && !oVGA_H_SYNC && fall_x < 0) fall_x = int'(oCoord_X);
            prev_hs = oVGA_H_SYNC;
            if (i == 0)   chk("pat_x0", 32'({oVGA_R, oVGA_G, oVGA_B}), 32'(pat_exp[0]));
            if (i == 80)  chk("pat_x80", 32'({oVGA_R, oVGA_G, oVGA_B}), 32'(pat_exp[1]));
            if (i == 560) chk("pat_x560", 32'({oVGA_R, oVGA_G, oVGA_B}), 32'(pat_exp[2]));
        end
        chk("hsync_low_count", 32'(hs_low), 32'd96);
        chk("hsync_fall_x", 32'(fall_x), 32'd657);

        // line 1: white input, count visible and blanked strobes
        iPattern_sel = 1'b0;
        iRed = 8'hFF; iGreen = 8'hFF; iBlue = 8'hFF;
        vis_ff   = 0;
        blk_zero = 0;
        for (int i = 0; i < 800; i++) begin
            cyc();
            if (oVGA_BLANK && {oVGA_R, oVGA_G, oVGA_B} == 24'hFFFFFF) vis_ff++;
            if (!oVGA_BLANK && {oVGA_R, oVGA_G, oVGA_B} == 24'h0) blk_zero++;
        end
        chk("line_visible_count", 32'(vis_ff), 32'd640);
        chk("line_blank_count", 32'(blk_zero), 32'd160);

        // random strobes, colours and pattern select
        for (int i = 0; i < 1500; i++) begin
            enable       = ($urandom_range(0, 3) != 0);
            iPattern_sel = 1'($urandom);
            rand_colour();
            cyc();
        end

        // reset in the middle of a frame
        jump_to(299, 100);
        enable = 1'b1;
        rand_colour();
        cyc();
        chk("pre_rst_x", 32'(oCoord_X), 32'd300);
        chk("pre_rst_y", 32'(oCoord_Y), 32'd100);
        resetn = 1'b0;
        #1;
        chk("midrst_x", 32'(oCoord_X), 32'd0);
        chk("midrst_y", 32'(oCoord_Y), 32'd0);
        chk("midrst_rgb", 32'({oVGA_R, oVGA_G, oVGA_B}), 32'd0);
        chk("midrst_hsync", 32'(oVGA_H_SYNC), 32'd1);
        chk("midrst_vsync", 32'(oVGA_V_SYNC), 32'd1);
        chk("midrst_blank", 32'(oVGA_BLANK), 32'd0);
        model_reset();
        for (int i = 0; i < 4; i++) begin
            enable = 1'($urandom);
            cyc();
        end
        resetn = 1'b1;
        enable = 1'b1;
        cyc();
        chk("post_rst_x", 32'(oCoord_X), 32'd1);
        chk("post_rst_y", 32'(oCoord_Y), 32'd0);

        // vertical sync: lines 488..491 inclusive
        jump_to(0, 488);
        enable = 1'b1;
        vs_low = 0;
        for (int i = 0; i < 3200; i++) begin
            rand_colour();
            cyc();
            if (!oVGA_V_SYNC) vs_low++;
        end
        chk("vsync_low_count", 32'(vs_low), 32'd1600);

        // end of frame with the nominal every-other-cycle strobe
        jump_to(780, 524);
        fs_cnt = 0;
        for (int i = 0; i < 80; i++) begin
            enable = (i % 2 == 1);
            rand_colour();
            #1;
            if (oFrame_start) fs_cnt++;
            cyc();
        end
        chk("frame_start_cycles", 32'(fs_cnt), 32'd1);
        chk("wrap_x", 32'(oCoord_X), 32'd20);
        chk("wrap_y", 32'(oCoord_Y), 32'd0);

        // hold at the last visible pixel
        jump_to(638, 479);
        iRed = 8'h12; iGreen = 8'h34; iBlue = 8'h56;
        enable = 1'b1;
        cyc();
        enable = 1'b0;
        for (int i = 0; i < 10; i++) begin
            cyc();
            chk("hold_x", 32'(oCoord_X), 32'd639);
            chk("hold_rgb", 32'({oVGA_R, oVGA_G, oVGA_B}), 32'h123456);
            chk("hold_blank", 32'(oVGA_BLANK), 32'd1);
        end
        enable = 1'b1;
        cyc();
        chk("after_hold_x", 32'(oCoord_X), 32'd640);
        chk("after_hold_y", 32'(oCoord_Y), 32'd479);
        cyc();
        chk("after_hold_blank", 32'(oVGA_BLANK), 32'd0);
        chk("after_hold_rgb", 32'({oVGA_R, oVGA_G, oVGA_B}), 32'd0);

        for (int i = 0; i < 500; i++) begin
            enable       = 1'($urandom);
            iPattern_sel = 1'($urandom);
            rand_colour();
            cyc();
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
